// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams packed instruction words
// into instruction memory from a base address.
module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              full,
   output logic              err,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [31:0]       enc;
   logic              accept;
   logic              legal;

   // imem never back-pressures, so the output stage drains every
   // cycle and a new bundle can follow a pending write directly.
   assign full     = (count == CAP);
   assign in_ready = (state == LOAD) && !full;
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign legal    = (in_fmt <= FMT_J);

   always_comb begin
      enc = '0;
      unique case (in_fmt)
         FMT_R: enc = {in_funct7, in_rs2, in_rs1,
                       in_funct3, in_rd, in_opcode};
         FMT_I: enc = {in_imm[11:0], in_rs1,
                       in_funct3, in_rd, in_opcode};
         FMT_S: enc = {in_imm[11:5], in_rs2, in_rs1,
                       in_funct3, in_imm[4:0], in_opcode};
         FMT_B: enc = {in_imm[12], in_imm[10:5], in_rs2,
                       in_rs1, in_funct3, in_imm[4:1],
                       in_imm[11], in_opcode};
         FMT_U: enc = {in_imm[31:12], in_rd, in_opcode};
         FMT_J: enc = {in_imm[20], in_imm[10:1], in_imm[11],
                       in_imm[19:12], in_rd, in_opcode};
         default: enc = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         count      <= '0;
         err        <= 1'b0;
         done       <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         done    <= 1'b0;
         imem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= LOAD;
                  count  <= '0;
                  err    <= 1'b0;
                  wr_ptr <= base_addr;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (legal) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= wr_ptr;
                     imem_wdata <= enc;
                     wr_ptr     <= wr_ptr + ADDR_W'(1);
                     count      <= count + (ADDR_W+1)'(1);
                  end else begin
                     err <= 1'b1;
                  end
               end
               if (finish) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (!imem_we) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: an 8-bit and a
// 2-bit address instance share clock, reset and field inputs.
module tb_instr_encoder_loader;

   logic        clk;
   logic        rst_n;
   logic [2:0]  fmt;
   logic [6:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm;

   logic        a_start, a_finish, a_valid;
   logic [7:0]  a_base;
   logic        a_ready, a_we, a_busy, a_full, a_err, a_done;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_count;

   logic        b_start, b_finish, b_valid;
   logic [1:0]  b_base;
   logic        b_ready, b_we, b_busy, b_full, b_err, b_done;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   logic [7:0] a_ptr;
   logic [1:0] b_ptr;

   int errors = 0;
   int checks = 0;

   instr_encoder_loader #(.ADDR_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .start(a_start), .base_addr(a_base), .finish(a_finish),
      .in_valid(a_valid), .in_ready(a_ready),
      .in_fmt(fmt), .in_opcode(op), .in_rd(rd),
      .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3),
      .in_funct7(f7), .in_imm(imm),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .count(a_count), .busy(a_busy), .full(a_full),
      .err(a_err), .done(a_done)
   );

   instr_encoder_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .start(b_start), .base_addr(b_base), .finish(b_finish),
      .in_valid(b_valid), .in_ready(b_ready),
      .in_fmt(fmt), .in_opcode(op), .in_rd(rd),
      .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3),
      .in_funct7(f7), .in_imm(imm),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .count(b_count), .busy(b_busy), .full(b_full),
      .err(b_err), .done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(
      input logic [2:0] f, input logic [6:0] o,
      input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [31:0] im);
      logic [31:0] w;
      w = '0;
      w[6:0] = o;
      case (f)
         3'd0: begin
            w[11:7] = d; w[14:12] = fn3; w[19:15] = s1;
            w[24:20] = s2; w[31:25] = fn7;
         end
         3'd1: begin
            w[11:7] = d; w[14:12] = fn3; w[19:15] = s1;
            w[31:20] = im[11:0];
         end
         3'd2: begin
            w[11:7] = im[4:0]; w[14:12] = fn3; w[19:15] = s1;
            w[24:20] = s2; w[31:25] = im[11:5];
         end
         3'd3: begin
            w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = fn3;
            w[19:15] = s1; w[24:20] = s2; w[30:25] = im[10:5];
            w[31] = im[12];
         end
         3'd4: begin
            w[11:7] = d; w[31:12] = im[31:12];
         end
         3'd5: begin
            w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11];
            w[30:21] = im[10:1]; w[31] = im[20];
         end
         default: w = '0;
      endcase
      return w;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (a_we === 1'b1) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_write", 64'(a_addr), 64'hFFFF);
         end else begin
            e = qa.pop_front();
            chk("a_addr", 64'(a_addr), 64'(e.addr));
            chk("a_data", 64'(a_wdata), 64'(e.data));
         end
      end
      if (b_we === 1'b1) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_write", 64'(b_addr), 64'hFFFF);
         end else begin
            e = qb.pop_front();
            chk("b_addr", 64'(b_addr), 64'(e.addr));
            chk("b_data", 64'(b_wdata), 64'(e.data));
         end
      end
   end

   task automatic do_start(input int which, input logic [7:0] base);
      if (which == 0) begin
         a_start = 1'b1; a_base = base; a_ptr = base;
      end else begin
         b_start = 1'b1; b_base = base[1:0]; b_ptr = base[1:0];
      end
      @(posedge clk); #1;
      a_start = 1'b0;
      b_start = 1'b0;
      chk("start_busy", 64'(which == 0 ? a_busy : b_busy), 64'd1);
   endtask

   task automatic send(input int which, input logic [2:0] f,
                       input logic [6:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [31:0] im, input logic fin);
      logic ok;
      logic rdy;
      exp_t e;
      fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2;
      f3 = fn3; f7 = fn7; imm = im;
      if (which == 0) begin
         a_valid = 1'b1; a_finish = fin;
      end else begin
         b_valid = 1'b1; b_finish = fin;
      end
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         rdy = (which == 0) ? a_ready : b_ready;
         @(posedge clk); #1;
         if (rdy) ok = 1'b1;
      end
      a_valid = 1'b0; a_finish = 1'b0;
      b_valid = 1'b0; b_finish = 1'b0;
      if (!ok) begin
         chk("send_timeout", 64'd0, 64'd1);
      end else if (f <= 3'd5) begin
         e.data = model(f, o, d, s1, s2, fn3, fn7, im);
         if (which == 0) begin
            e.addr = a_ptr; a_ptr = a_ptr + 8'd1; qa.push_back(e);
         end else begin
            e.addr = {6'd0, b_ptr}; b_ptr = b_ptr + 2'd1;
            qb.push_back(e);
         end
      end
   endtask

   task automatic wait_done(input int which);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if ((which == 0 ? a_done : b_done) === 1'b1) seen = 1'b1;
      end
      chk("done_pulse", 64'(seen), 64'd1);
      chk("idle_busy", 64'(which == 0 ? a_busy : b_busy), 64'd0);
   endtask

   task automatic do_finish(input int which);
      if (which == 0) a_finish = 1'b1;
      else b_finish = 1'b1;
      @(posedge clk); #1;
      a_finish = 1'b0;
      b_finish = 1'b0;
      wait_done(which);
   endtask

   task automatic send_rand(input int which);
      logic [2:0] f;
      f = 3'($urandom_range(0, 5));
      send(which, f, 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 3'($urandom), 7'($urandom),
           32'($urandom), 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      a_start = 0; a_finish = 0; a_valid = 0; a_base = '0;
      b_start = 0; b_finish = 0; b_valid = 0; b_base = '0;
      fmt = '0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
      f3 = '0; f7 = '0; imm = '0;
      a_ptr = '0; b_ptr = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 64'(a_we), 64'd0);
      chk("rst_addr", 64'(a_addr), 64'd0);
      chk("rst_wdata", 64'(a_wdata), 64'd0);
      chk("rst_count", 64'(a_count), 64'd0);
      chk("rst_busy", 64'(a_busy), 64'd0);
      chk("rst_full", 64'(a_full), 64'd0);
      chk("rst_err", 64'(a_err), 64'd0);
      chk("rst_done", 64'(a_done), 64'd0);
      chk("rst_ready", 64'(a_ready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_start(0, 8'h10);
      chk("load_ready", 64'(a_ready), 64'd1);
      send(0, 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0,
           32'd0, 1'b0);
      chk("r_we", 64'(a_we), 64'd1);
      chk("r_addr", 64'(a_addr), 64'h10);
      chk("r_wdata", 64'(a_wdata), 64'h002081B3);
      chk("r_count", 64'(a_count), 64'd1);
      do_finish(0);

      do_start(0, 8'h10);
      send(0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
           32'd5, 1'b0);
      chk("i_we", 64'(a_we), 64'd1);
      chk("i_addr", 64'(a_addr), 64'h10);
      chk("i_wdata", 64'(a_wdata), 64'h00500093);
      send(0, 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
           32'hFFFFFFFC, 1'b1);
      chk("b_we_b2b", 64'(a_we), 64'd1);
      chk("b_addr", 64'(a_addr), 64'h11);
      chk("b_wdata", 64'(a_wdata), 64'hFE000EE3);
      chk("b2b_count", 64'(a_count), 64'd2);
      chk("fin_accept_ready", 64'(a_ready), 64'd0);
      wait_done(0);

      do_start(0, 8'($urandom));
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send_rand(0);
      end
      chk("rnd_count", 64'(a_count), 64'd24);
      do_finish(0);

      do_start(0, 8'h40);
      send(0, 3'd6, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,
           32'd0, 1'b0);
      chk("ill_we", 64'(a_we), 64'd0);
      chk("ill_err", 64'(a_err), 64'd1);
      chk("ill_count", 64'(a_count), 64'd0);
      send(0, 3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0,
           32'd0, 1'b0);
      send(0, 3'd2, 7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0,
           32'hFFFFF800, 1'b0);
      chk("ill_then_count", 64'(a_count), 64'd1);
      chk("ill_sticky", 64'(a_err), 64'd1);
      do_finish(0);
      do_start(0, 8'h00);
      chk("err_cleared", 64'(a_err), 64'd0);
      chk("count_cleared", 64'(a_count), 64'd0);
      do_finish(0);

      do_start(1, 8'd3);
      for (int i = 0; i < 4; i++) send_rand(1);
      chk("small_full", 64'(b_full), 64'd1);
      chk("small_ready", 64'(b_ready), 64'd0);
      chk("small_count", 64'(b_count), 64'd4);
      b_valid = 1'b1;
      @(negedge clk);
      chk("small_ready_hold", 64'(b_ready), 64'd0);
      b_valid = 1'b0;
      do_finish(1);

      do_start(0, 8'h80);
      send(0, 3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0,
           32'h12345000, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mrst_we", 64'(a_we), 64'd0);
      chk("mrst_busy", 64'(a_busy), 64'd0);
      chk("mrst_count", 64'(a_count), 64'd0);
      chk("mrst_ready", 64'(a_ready), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mrst_no_write", 64'(a_we), 64'd0);

      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
